// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bus bundle for if_prefetch_queue: ROM request/response, ID handshake and branch redirect.
// master = the prefetch queue, slave = the surrounding pipeline/ROM.
interface if_prefetch_queue_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic               BranchTaken;
  logic [PC_W-1:0]    BranchTarget;
  logic               ID_Stall;
  logic               rom_req;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               IF_ID_Valid;
  logic [INSTR_W-1:0] IF_ID_Instruction;
  logic [PC_W-1:0]    IF_ID_PC;

  modport master (
    input  BranchTaken, BranchTarget, ID_Stall, rom_data,
    output rom_req, rom_addr, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC
  );

  modport slave (
    output BranchTaken, BranchTarget, ID_Stall, rom_data,
    input  rom_req, rom_addr, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue between a 1-cycle-latency ROM and ID, with branch redirect/flush.
// Optional IFQ_PERF_EN adds starve_cnt/flush_cnt performance counters.
module if_prefetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input logic clk,
  input logic rst,
  if_prefetch_queue_if.master bus
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0] starve_cnt,
  output logic [7:0]  flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;
  logic [CW-1:0]      occ;
  logic               issue, push, pop, head_vld;

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  // Occupancy counts the outstanding fetch so a returning response always has a free slot.
  always_comb begin
    occ      = count_q + CW'(inflight_q);
    head_vld = (count_q != '0);
    issue    = rst && !bus.BranchTaken && (occ < CW'(DEPTH));
    push     = inflight_q && !drop_q && !bus.BranchTaken;
    pop      = head_vld && !bus.ID_Stall && !bus.BranchTaken;
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    drop_d     = 1'b0;
    if (bus.BranchTaken) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = bus.BranchTarget;
      inflight_d = 1'b0;
      drop_d     = inflight_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
        tag_d      = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_pc_q <= PC_W'(RESET_PC);
      tag_q      <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage is data only; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= tag_q;
      instr_mem_q[wr_ptr_q] <= bus.rom_data;
    end
  end

  assign bus.rom_req           = issue;
  assign bus.rom_addr          = fetch_pc_q;
  assign bus.IF_ID_Valid       = head_vld;
  assign bus.IF_ID_Instruction = head_vld ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.IF_ID_PC          = head_vld ? pc_mem_q[rd_ptr_q] : '0;

`ifdef IFQ_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]  br_hist_q;
  logic [15:0] starve_q;
  logic [7:0]  flush_q;

  // Empty cycles shortly after a redirect are refill latency, not starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_hist_q <= '0;
      starve_q  <= '0;
      flush_q   <= '0;
    end else begin
      br_hist_q <= {br_hist_q[0], bus.BranchTaken};
      if (!head_vld && (br_hist_q == 2'b00)) starve_q <= sat_inc16(starve_q);
      if (bus.BranchTaken) flush_q <= sat_inc8(flush_q);
    end
  end

  assign starve_cnt = starve_q;
  assign flush_cnt  = flush_q;
`endif
endmodule
